mem_stage: RTL

- Pipeline MEM stage of the 5-stage MIPS core. Sits directly downstream of the EX/MEM latch and consumes its outputs.
- Runs the data-memory request handshake with the cache/memory controller and stalls the pipeline until dhit.
- Selects the writeback value (load data, ALU result, JAL link, LUI) and registers it into the MEM/WB latch.
- Exports combinational forwarding data for the hazard unit.

---
 rtl/mem_stage_pkg.sv | 21 ++
 rtl/mem_stage_if.sv | 26 ++
 rtl/mem_stage_wb.sv | 48 ++++
 rtl/mem_stage.sv | 132 +++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types for the MEM pipeline stage: datapath widths and the
// data-access handshake state encoding.
package mem_stage_pkg;

    localparam int CPU_WORD_W = 32;
    localparam int CPU_REG_AW = 5;

    typedef logic [CPU_WORD_W-1:0] word_t;
    typedef logic [CPU_REG_AW-1:0] regbits_t;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        ACCESS = ST_ACCESS,
        DONE   = ST_DONE
    } memstage_state_t;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request bus between the MEM stage (master) and the
// cache/memory controller (slave).
interface mem_stage_if
    import mem_stage_pkg::*;
#(
    parameter int WORD_W = CPU_WORD_W
);

    logic              dmemREN;
    logic              dmemWEN;
    logic [WORD_W-1:0] dmemaddr;
    logic [WORD_W-1:0] dmemstore;
    logic              dhit;
    logic [WORD_W-1:0] dmemload;

    modport master (
        output dmemREN, dmemWEN, dmemaddr, dmemstore,
        input  dhit, dmemload
    );

    modport slave (
        input  dmemREN, dmemWEN, dmemaddr, dmemstore,
        output dhit, dmemload
    );

endinterface

// File: rtl/mem_stage_wb.sv
// MEM/WB pipeline latch: load on advance, bubble on stalled advance,
// otherwise hold. The halt flag is sticky until reset.
module mem_wb
    import mem_stage_pkg::*;
#(
    parameter int WORD_W = CPU_WORD_W,
    parameter int REG_AW = CPU_REG_AW
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              adv,
    input  logic              bubble,
    input  logic              valid,
    input  logic              regWEN,
    input  logic              halt,
    input  logic [REG_AW-1:0] wsel,
    input  logic [WORD_W-1:0] wdat,
    input  logic [WORD_W-1:0] instr,
    output logic              wb_valid,
    output logic              wb_regWEN,
    output logic              wb_halt,
    output logic [REG_AW-1:0] wb_wsel,
    output logic [WORD_W-1:0] wb_wdat,
    output logic [WORD_W-1:0] wb_instr
);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wb_valid  <= 1'b0;
            wb_regWEN <= 1'b0;
            wb_halt   <= 1'b0;
            wb_wsel   <= '0;
            wb_wdat   <= '0;
            wb_instr  <= '0;
        end else if (adv) begin
            wb_valid  <= valid;
            wb_regWEN <= regWEN;
            wb_halt   <= wb_halt | halt;
            wb_wsel   <= wsel;
            wb_wdat   <= wdat;
            wb_instr  <= instr;
        end else if (bubble) begin
            wb_valid  <= 1'b0;
            wb_regWEN <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: data-memory handshake, writeback select, forwarding
// data and the MEM/WB latch.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int WORD_W = CPU_WORD_W,
    parameter int REG_AW = CPU_REG_AW
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              ihit,
    input  logic              valid_i,
    input  logic              dREN_i,
    input  logic              dWEN_i,
    input  logic              regWEN_i,
    input  logic              memToReg_i,
    input  logic              jal_i,
    input  logic              lui_i,
    input  logic              halt_i,
    input  logic [REG_AW-1:0] wsel_i,
    input  logic [WORD_W-1:0] out_i,
    input  logic [WORD_W-1:0] rdat2_i,
    input  logic [WORD_W-1:0] next_pc_i,
    input  logic [15:0]       imm_i,
    input  logic [WORD_W-1:0] instr_i,
    mem_stage_if.master       dmem,
    output logic              mem_stall,
    output logic              fwd_wen,
    output logic [REG_AW-1:0] fwd_wsel,
    output logic [WORD_W-1:0] fwd_wdat,
    output logic              wb_valid,
    output logic              wb_regWEN,
    output logic              wb_halt,
    output logic [REG_AW-1:0] wb_wsel,
    output logic [WORD_W-1:0] wb_wdat,
    output logic [WORD_W-1:0] wb_instr
);

    memstage_state_t   state, state_n;
    logic              halted;
    logic              memop;
    logic              adv;
    logic              bubble;
    logic [WORD_W-1:0] ldbuf;
    logic [WORD_W-1:0] ld_data;

    // Gated by nRST so a reset mid-access withdraws the request at once.
    assign memop = nRST & valid_i & (dREN_i | dWEN_i) & ~halted;

    assign dmem.dmemREN   = memop & dREN_i & (state != DONE);
    assign dmem.dmemWEN   = memop & dWEN_i & (state != DONE);
    assign dmem.dmemaddr  = {out_i[WORD_W-1:2], 2'b00};
    assign dmem.dmemstore = rdat2_i;

    assign mem_stall = memop & (state != DONE) & ~dmem.dhit;
    assign adv       = ihit & ~mem_stall;
    assign bubble    = ihit & mem_stall;

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (memop && !dmem.dhit)
                    state_n = ACCESS;
                else if (memop && dmem.dhit && !ihit)
                    state_n = DONE;
            end
            ACCESS: begin
                if (dmem.dhit)
                    state_n = ihit ? IDLE : DONE;
            end
            DONE: begin
                if (ihit)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state  <= IDLE;
            halted <= 1'b0;
            ldbuf  <= '0;
        end else begin
            state <= state_n;
            if (adv && valid_i && halt_i)
                halted <= 1'b1;
            if (dmem.dhit && dREN_i)
                ldbuf <= dmem.dmemload;
        end
    end

    assign ld_data = dmem.dhit ? dmem.dmemload : ldbuf;

    always_comb begin
        if (jal_i)
            fwd_wdat = next_pc_i;
        else if (lui_i)
            fwd_wdat = WORD_W'({imm_i, 16'h0000});
        else if (memToReg_i)
            fwd_wdat = ld_data;
        else
            fwd_wdat = out_i;
    end

    assign fwd_wen  = valid_i & regWEN_i & ~(memToReg_i & mem_stall);
    assign fwd_wsel = wsel_i;

    mem_wb #(
        .WORD_W (WORD_W),
        .REG_AW (REG_AW)
    ) u_mem_wb (
        .CLK       (CLK),
        .nRST      (nRST),
        .adv       (adv),
        .bubble    (bubble),
        .valid     (valid_i),
        .regWEN    (regWEN_i),
        .halt      (halt_i),
        .wsel      (wsel_i),
        .wdat      (fwd_wdat),
        .instr     (instr_i),
        .wb_valid  (wb_valid),
        .wb_regWEN (wb_regWEN),
        .wb_halt   (wb_halt),
        .wb_wsel   (wb_wsel),
        .wb_wdat   (wb_wdat),
        .wb_instr  (wb_instr)
    );

endmodule
